// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 1-to-4 TDM demultiplexer: slot count, slot
// counter type and the framing state encoding.
package tdm_demux_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned CNT_W = $clog2(NCH);

  typedef logic [CNT_W-1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam slot_t FIRST_SLOT = slot_t'(0);
  localparam slot_t LAST_SLOT  = slot_t'(NCH - 1);

  function automatic slot_t next_slot(input slot_t s);
    return slot_t'(s + slot_t'(1));
  endfunction

endpackage

// File: rtl/tdm_slot_bank.sv
// Shadow slot registers plus the output frame register; the last slot is
// taken straight from the input so the whole frame commits in one edge.
module tdm_slot_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [$clog2(NCH)-1:0]   wr_slot_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     commit_i,
  output logic [NCH*WIDTH-1:0]     dout_o
);

  localparam int unsigned SW = $clog2(NCH);

  logic [WIDTH-1:0]     shadow_q [NCH-1];
  logic [NCH*WIDTH-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH - 1; i++) begin
        shadow_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NCH - 1; i++) begin
        if (wr_en_i && (wr_slot_i == SW'(i))) begin
          shadow_q[i] <= wr_data_i;
        end
      end
      if (commit_i) begin
        for (int unsigned i = 0; i < NCH - 1; i++) begin
          dout_q[i*WIDTH +: WIDTH] <= shadow_q[i];
        end
        dout_q[(NCH-1)*WIDTH +: WIDTH] <= wr_data_i;
      end
    end
  end

  assign dout_o = dout_q;

endmodule

// File: rtl/tdm_demux_1x4.sv
// Frame-synchronised 1-to-4 TDM demultiplexer: hunts for fsync, collects four
// slots and publishes each complete frame with a one-cycle valid pulse.
module tdm_demux_1x4 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = tdm_demux_pkg::NCH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_vld,
  input  logic                 fsync,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 dout_vld,
  output logic                 sync_err,
  output logic                 locked
);

  import tdm_demux_pkg::*;

  state_e state_q;
  slot_t  cnt_q;
  logic   dout_vld_q;
  logic   sync_err_q;
  logic   locked_q;

  logic   wr_en;
  slot_t  wr_slot;
  logic   commit;

  // Bank control: fsync always (re)starts at slot 0; the final slot bypasses
  // the shadow bank and commits directly.
  always_comb begin
    wr_en   = 1'b0;
    wr_slot = FIRST_SLOT;
    commit  = 1'b0;
    if (din_vld) begin
      unique case (state_q)
        HUNT: begin
          wr_en = fsync;
        end
        LOCKED: begin
          if (fsync) begin
            wr_en = 1'b1;
          end else if (cnt_q == LAST_SLOT) begin
            commit = 1'b1;
          end else if (cnt_q != FIRST_SLOT) begin
            wr_en   = 1'b1;
            wr_slot = cnt_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      cnt_q      <= FIRST_SLOT;
      dout_vld_q <= 1'b0;
      sync_err_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      dout_vld_q <= 1'b0;
      sync_err_q <= 1'b0;
      if (din_vld) begin
        unique case (state_q)
          HUNT: begin
            if (fsync) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              cnt_q    <= next_slot(FIRST_SLOT);
            end
          end
          LOCKED: begin
            if (fsync) begin
              sync_err_q <= (cnt_q != FIRST_SLOT);
              cnt_q      <= next_slot(FIRST_SLOT);
            end else if (cnt_q == FIRST_SLOT) begin
              sync_err_q <= 1'b1;
              state_q    <= HUNT;
              locked_q   <= 1'b0;
            end else if (cnt_q == LAST_SLOT) begin
              dout_vld_q <= 1'b1;
              cnt_q      <= FIRST_SLOT;
            end else begin
              cnt_q <= next_slot(cnt_q);
            end
          end
          default: begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
            cnt_q    <= FIRST_SLOT;
          end
        endcase
      end
    end
  end

  tdm_slot_bank #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) u_slot_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_en),
    .wr_slot_i (wr_slot),
    .wr_data_i (din),
    .commit_i  (commit),
    .dout_o    (dout)
  );

  assign dout_vld = dout_vld_q;
  assign sync_err = sync_err_q;
  assign locked   = locked_q;

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Directed and randomised checks of tdm_demux_1x4 against a queue-based
// frame model.
module tb_tdm_demux_1x4;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   din = '0;
  logic           din_vld = 1'b0;
  logic           fsync = 1'b0;
  logic [N*W-1:0] dout;
  logic           dout_vld;
  logic           sync_err;
  logic           locked;

  int checks = 0;
  int failures = 0;

  // Reference model: samples of the frame being collected, plus lock flag.
  logic [W-1:0]   m_q[$];
  bit             m_locked = 1'b0;
  logic [N*W-1:0] m_dout = '0;
  bit             m_vld = 1'b0;
  bit             m_err = 1'b0;

  tdm_demux_1x4 #(
    .WIDTH (W),
    .NCH   (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .din_vld  (din_vld),
    .fsync    (fsync),
    .dout     (dout),
    .dout_vld (dout_vld),
    .sync_err (sync_err),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"}, 64'(dout), 64'(m_dout));
    check({tag, ".dout_vld"}, 64'(dout_vld), 64'(m_vld));
    check({tag, ".sync_err"}, 64'(sync_err), 64'(m_err));
    check({tag, ".locked"}, 64'(locked), 64'(m_locked));
    check({tag, ".exclusive"}, 64'(dout_vld & sync_err), 64'(0));
  endtask

  task automatic model_step(input bit v, input bit fs, input logic [W-1:0] d);
    m_vld = 1'b0;
    m_err = 1'b0;
    if (!v) return;
    if (fs) begin
      if (m_locked && m_q.size() != 0) m_err = 1'b1;
      m_q.delete();
      m_q.push_back(d);
      m_locked = 1'b1;
    end else if (!m_locked) begin
      // hunting: sample ignored
    end else if (m_q.size() == 0) begin
      m_err = 1'b1;
      m_locked = 1'b0;
    end else begin
      m_q.push_back(d);
      if (m_q.size() == N) begin
        for (int k = 0; k < N; k++) m_dout[k*W +: W] = m_q[k];
        m_vld = 1'b1;
        m_q.delete();
      end
    end
  endtask

  task automatic step(input string tag, input bit v, input bit fs, input logic [W-1:0] d);
    din_vld = v;
    fsync = fs;
    din = d;
    @(posedge clk);
    #1;
    model_step(v, fs, d);
    din_vld = 1'b0;
    fsync = 1'b0;
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    m_q.delete();
    m_locked = 1'b0;
    m_dout = '0;
    m_vld = 1'b0;
    m_err = 1'b0;
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    #1;
    m_dout = '0;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, back to back
    step("f1.s0", 1, 1, 8'h11);
    step("f1.s1", 1, 0, 8'h22);
    step("f1.s2", 1, 0, 8'h33);
    step("f1.s3", 1, 0, 8'h44);
    check("f1.value", 64'(dout), 64'h44332211);
    step("f1.idle", 0, 0, 8'h00);

    // Same frame with gaps
    step("f2.s0", 1, 1, 8'h11);
    step("f2.gap0", 0, 1, 8'hEE);
    step("f2.s1", 1, 0, 8'h22);
    step("f2.gap1", 0, 0, 8'hEE);
    step("f2.s2", 1, 0, 8'h33);
    step("f2.gap2", 0, 0, 8'hEE);
    step("f2.s3", 1, 0, 8'h44);
    step("f2.after", 0, 0, 8'h00);

    // Early sync drops the partial frame
    step("es.s0", 1, 1, 8'h01);
    step("es.s1", 1, 0, 8'h02);
    step("es.resync", 1, 1, 8'h05);
    check("es.err", 64'(sync_err), 64'(1));
    step("es.s1b", 1, 0, 8'h06);
    step("es.s2b", 1, 0, 8'h07);
    check("es.hold", 64'(dout), 64'h44332211);
    step("es.s3b", 1, 0, 8'h08);
    check("es.value", 64'(dout), 64'h08070605);

    // Missing sync after a complete frame
    step("ms.sample", 1, 0, 8'h99);
    check("ms.unlocked", 64'(locked), 64'(0));
    step("ms.after", 0, 0, 8'h00);

    // Hunting discards unsynchronised samples
    step("hunt.aa", 1, 0, 8'hAA);
    step("hunt.bb", 1, 0, 8'hBB);

    // Reset mid-frame, then a fresh frame
    step("rst.s0", 1, 1, 8'hC1);
    step("rst.s1", 1, 0, 8'hC2);
    step("rst.s2", 1, 0, 8'hC3);
    async_reset("rst.async");
    step("rst.noframe", 1, 0, 8'hC4);
    step("rst.n0", 1, 1, 8'hD1);
    step("rst.n1", 1, 0, 8'hD2);
    step("rst.n2", 1, 0, 8'hD3);
    step("rst.n3", 1, 0, 8'hD4);
    check("rst.value", 64'(dout), 64'hD4D3D2D1);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        async_reset("rnd.reset");
      end else begin
        step("rnd", $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, W'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
